accel_profile_sequencer: RTL and testbench

ACCEL_PROFILE_SEQUENCER -- requirements
Module: accel_profile_sequencer

---
 rtl/hil_sim_pkg.sv | 15 +
 rtl/profile_table.sv | 41 ++++
 rtl/accel_profile_sequencer.sv | 155 +++++++++++++++
 tb/tb_accel_profile_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hil_sim_pkg.sv
// Shared definitions for the HIL acceleration-profile sequencer and the pod model.
package hil_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_NUM_SEG = 8;
  localparam int unsigned DEF_TIME_W  = 32;
  localparam int unsigned DEF_ACCEL_W = 32;

endpackage

// File: rtl/profile_table.sv
// Segment table: NUM_SEG entries of {end time, signed accel}, one write port,
// one asynchronous read port. Contents are not reset.
module profile_table
  import hil_sim_pkg::*;
#(
  parameter int unsigned NUM_SEG = DEF_NUM_SEG,
  parameter int unsigned TIME_W  = DEF_TIME_W,
  parameter int unsigned ACCEL_W = DEF_ACCEL_W
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_SEG)-1:0] wr_addr,
  input  logic [TIME_W-1:0]          wr_end,
  input  logic [ACCEL_W-1:0]         wr_accel,
  input  logic [$clog2(NUM_SEG)-1:0] rd_addr,
  output logic [TIME_W-1:0]          rd_end,
  output logic [ACCEL_W-1:0]         rd_accel
);

  logic [TIME_W-1:0]  end_mem   [NUM_SEG];
  logic [ACCEL_W-1:0] accel_mem [NUM_SEG];

  // Register-file write; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < NUM_SEG)) begin
      end_mem[wr_addr]   <= wr_end;
      accel_mem[wr_addr] <= wr_accel;
    end
  end

  // Asynchronous read; out-of-range addresses return zero.
  always_comb begin
    rd_end   = '0;
    rd_accel = '0;
    if (32'(rd_addr) < NUM_SEG) begin
      rd_end   = end_mem[rd_addr];
      rd_accel = accel_mem[rd_addr];
    end
  end

endmodule

// File: rtl/accel_profile_sequencer.sv
// Plays a piecewise-constant acceleration profile from a segment table,
// advancing on 1 kHz ticks, with pause, abort and error handling.
module accel_profile_sequencer
  import hil_sim_pkg::*;
#(
  parameter int unsigned NUM_SEG = DEF_NUM_SEG,
  parameter int unsigned TIME_W  = DEF_TIME_W,
  parameter int unsigned ACCEL_W = DEF_ACCEL_W
) (
  input  logic                       CLK_50MHZ,
  input  logic                       RST,
  input  logic                       tick,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_SEG)-1:0] wr_addr,
  input  logic [TIME_W-1:0]          wr_end,
  input  logic [ACCEL_W-1:0]         wr_accel,
  input  logic [$clog2(NUM_SEG):0]   seg_count,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       abort,
  output logic [ACCEL_W-1:0]         accel,
  output logic                       running,
  output logic [$clog2(NUM_SEG)-1:0] seg_idx,
  output logic [TIME_W-1:0]          elapsed,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned IDX_W = $clog2(NUM_SEG);
  localparam int unsigned CNT_W = IDX_W + 1;

  seq_state_e         state_q;
  logic [ACCEL_W-1:0] accel_q;
  logic [IDX_W-1:0]   seg_idx_q;
  logic [IDX_W-1:0]   last_idx_q;
  logic [TIME_W-1:0]  elapsed_q;
  logic [TIME_W-1:0]  elapsed_d;
  logic [TIME_W-1:0]  cur_end_q;
  logic               done_q;
  logic               error_q;

  logic               tbl_wr_en;
  logic [IDX_W-1:0]   rd_addr;
  logic [TIME_W-1:0]  rd_end;
  logic [ACCEL_W-1:0] rd_accel;
  logic               cnt_ok;
  logic               elapsed_max;

  // The single read port serves both start (entry 0) and segment advance
  // (entry seg_idx+1); the current end time is kept in cur_end_q instead.
  always_comb begin
    tbl_wr_en   = wr_en && (state_q == ST_IDLE || state_q == ST_DONE);
    rd_addr     = (state_q == ST_RUN || state_q == ST_PAUSE) ? seg_idx_q + IDX_W'(1) : '0;
    cnt_ok      = (seg_count != '0) && (seg_count <= CNT_W'(NUM_SEG));
    elapsed_d   = elapsed_q + TIME_W'(1);
    elapsed_max = &elapsed_q;
  end

  profile_table #(
    .NUM_SEG (NUM_SEG),
    .TIME_W  (TIME_W),
    .ACCEL_W (ACCEL_W)
  ) u_table (
    .clk      (CLK_50MHZ),
    .wr_en    (tbl_wr_en),
    .wr_addr  (wr_addr),
    .wr_end   (wr_end),
    .wr_accel (wr_accel),
    .rd_addr  (rd_addr),
    .rd_end   (rd_end),
    .rd_accel (rd_accel)
  );

  // Sequencer FSM with registered outputs; abort outranks everything but RST.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      accel_q    <= '0;
      seg_idx_q  <= '0;
      last_idx_q <= '0;
      elapsed_q  <= '0;
      cur_end_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        accel_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              if (cnt_ok) begin
                state_q    <= ST_RUN;
                elapsed_q  <= '0;
                seg_idx_q  <= '0;
                last_idx_q <= IDX_W'(seg_count - CNT_W'(1));
                accel_q    <= rd_accel;
                cur_end_q  <= rd_end;
                error_q    <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                accel_q <= '0;
                error_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSE;
            end else if (tick) begin
              if (elapsed_max) begin
                state_q <= ST_IDLE;
                accel_q <= '0;
                error_q <= 1'b1;
              end else begin
                elapsed_q <= elapsed_d;
                if (elapsed_d == cur_end_q) begin
                  if (seg_idx_q == last_idx_q) begin
                    state_q <= ST_DONE;
                    accel_q <= '0;
                    done_q  <= 1'b1;
                  end else if (rd_end <= cur_end_q) begin
                    state_q <= ST_IDLE;
                    accel_q <= '0;
                    error_q <= 1'b1;
                  end else begin
                    seg_idx_q <= seg_idx_q + IDX_W'(1);
                    accel_q   <= rd_accel;
                    cur_end_q <= rd_end;
                  end
                end
              end
            end
          end
          ST_PAUSE: begin
            if (!pause) begin
              state_q <= ST_RUN;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign accel   = accel_q;
  assign running = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign seg_idx = seg_idx_q;
  assign elapsed = elapsed_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_accel_profile_sequencer.sv
// Scoreboard bench for accel_profile_sequencer: every accel change or done
// pulse pops a predicted {accel, elapsed, seg_idx, done, error} record.
module tb_accel_profile_sequencer;

  localparam int unsigned NUM_SEG = 8;
  localparam int unsigned TIME_W  = 32;
  localparam int unsigned ACCEL_W = 32;

  logic        CLK_50MHZ;
  logic        RST;
  logic        tick;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_end;
  logic [31:0] wr_accel;
  logic [3:0]  seg_count;
  logic        start;
  logic        pause;
  logic        abort;
  logic [31:0] accel;
  logic        running;
  logic [2:0]  seg_idx;
  logic [31:0] elapsed;
  logic        done;
  logic        error;

  typedef struct {
    logic [31:0] accel;
    logic [31:0] elapsed;
    logic [2:0]  seg;
    logic        done;
    logic        err;
  } sb_item_t;

  sb_item_t    sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic        mon_en = 1'b0;
  logic [31:0] prev_accel = '0;

  accel_profile_sequencer #(
    .NUM_SEG (NUM_SEG),
    .TIME_W  (TIME_W),
    .ACCEL_W (ACCEL_W)
  ) dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .tick      (tick),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_end    (wr_end),
    .wr_accel  (wr_accel),
    .seg_count (seg_count),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .accel     (accel),
    .running   (running),
    .seg_idx   (seg_idx),
    .elapsed   (elapsed),
    .done      (done),
    .error     (error)
  );

  initial CLK_50MHZ = 1'b0;
  always #5 CLK_50MHZ = ~CLK_50MHZ;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] e, input logic [2:0] s,
                          input logic d, input logic er);
    sb_item_t it;
    it.accel = a; it.elapsed = e; it.seg = s; it.done = d; it.err = er;
    sb.push_back(it);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge CLK_50MHZ) begin
    if (mon_en && (accel !== prev_accel || done === 1'b1)) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_event", 64'(sb.size()), 64'd1);
      end else begin
        sb_item_t it;
        it = sb.pop_front();
        check_eq("sb_accel",   64'(accel),   64'(it.accel));
        check_eq("sb_elapsed", 64'(elapsed), 64'(it.elapsed));
        check_eq("sb_seg_idx", 64'(seg_idx), 64'(it.seg));
        check_eq("sb_done",    64'(done),    64'(it.done));
        check_eq("sb_error",   64'(error),   64'(it.err));
      end
    end
    prev_accel = accel;
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge CLK_50MHZ);
  endtask

  task automatic tick_once(input int unsigned gap);
    tick = 1'b1;
    @(negedge CLK_50MHZ);
    tick = 1'b0;
    if (gap > 1) cyc(gap - 1);
  endtask

  task automatic load_seg(input logic [2:0] i, input logic [31:0] e, input logic [31:0] a);
    wr_en = 1'b1; wr_addr = i; wr_end = e; wr_accel = a;
    @(negedge CLK_50MHZ);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] cnt);
    seg_count = cnt;
    start = 1'b1;
    @(negedge CLK_50MHZ);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick  = 1'b1;
    @(negedge CLK_50MHZ);
    abort = 1'b0;
    tick  = 1'b0;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #1500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_end = '0; wr_accel = '0;
    seg_count = '0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cyc(3);
    check_eq("rst_accel",   64'(accel),   64'd0);
    check_eq("rst_running", 64'(running), 64'd0);
    check_eq("rst_seg_idx", 64'(seg_idx), 64'd0);
    check_eq("rst_elapsed", 64'(elapsed), 64'd0);
    check_eq("rst_done",    64'(done),    64'd0);
    check_eq("rst_error",   64'(error),   64'd0);
    RST = 1'b0;
    cyc(1);
    mon_en = 1'b1;

    // Main profile, tick every 4 cycles, with a 100-tick pause at 3000.
    load_seg(3'd0, 32'd6000, 32'd18000);
    load_seg(3'd1, 32'd8000, 32'd0);
    load_seg(3'd2, 32'd20000, -32'sd9000);
    push_exp(32'd18000, 32'd0, 3'd0, 1'b0, 1'b0);
    do_start(4'd3);
    check_eq("run_running", 64'(running), 64'd1);
    for (int e = 1; e <= 20000; e++) begin
      if (e == 6000) begin
        check_eq("pre6000_accel",   64'(accel),   64'd18000);
        check_eq("pre6000_elapsed", 64'(elapsed), 64'd5999);
        push_exp(32'd0, 32'd6000, 3'd1, 1'b0, 1'b0);
      end
      if (e == 8000)  push_exp(-32'sd9000, 32'd8000, 3'd2, 1'b0, 1'b0);
      if (e == 20000) push_exp(32'd0, 32'd20000, 3'd2, 1'b1, 1'b0);
      tick_once(4);
      if (e == 100) load_seg(3'd1, 32'd8000, 32'd5555);
      if (e == 3000) begin
        pause = 1'b1;
        repeat (100) tick_once(4);
        check_eq("pause_elapsed", 64'(elapsed), 64'd3000);
        check_eq("pause_accel",   64'(accel),   64'd18000);
        check_eq("pause_seg_idx", 64'(seg_idx), 64'd0);
        check_eq("pause_running", 64'(running), 64'd1);
        pause = 1'b0;
        cyc(2);
      end
    end
    check_eq("done_one_cycle", 64'(done),    64'd0);
    check_eq("done_running",   64'(running), 64'd0);
    tick_once(4);
    tick_once(4);
    check_eq("done_elapsed_frozen", 64'(elapsed), 64'd20000);

    // Abort at elapsed 7000 (ticks every cycle), restarting from DONE.
    push_exp(32'd18000, 32'd0, 3'd0, 1'b0, 1'b0);
    do_start(4'd3);
    for (int e = 1; e <= 7000; e++) begin
      if (e == 6000) push_exp(32'd0, 32'd6000, 3'd1, 1'b0, 1'b0);
      tick_once(1);
    end
    check_eq("pre_abort_seg_idx", 64'(seg_idx), 64'd1);
    check_eq("pre_abort_elapsed", 64'(elapsed), 64'd7000);
    do_abort();
    check_eq("abort_accel",   64'(accel),   64'd0);
    check_eq("abort_running", 64'(running), 64'd0);
    check_eq("abort_done",    64'(done),    64'd0);
    check_eq("abort_error",   64'(error),   64'd0);
    cyc(2);

    // Non-increasing end times: 500 then 400.
    load_seg(3'd0, 32'd500, 32'd1000);
    load_seg(3'd1, 32'd400, 32'd2000);
    push_exp(32'd1000, 32'd0, 3'd0, 1'b0, 1'b0);
    do_start(4'd2);
    for (int e = 1; e <= 500; e++) begin
      if (e == 500) push_exp(32'd0, 32'd500, 3'd0, 1'b0, 1'b1);
      tick_once(1);
    end
    check_eq("order_err_error",   64'(error),   64'd1);
    check_eq("order_err_running", 64'(running), 64'd0);
    tick_once(1);
    check_eq("order_err_idle_elapsed", 64'(elapsed), 64'd500);

    // Bad seg_count values: 0 and NUM_SEG+1.
    push_exp(32'd1000, 32'd0, 3'd0, 1'b0, 1'b0);
    do_start(4'd1);
    check_eq("valid_start_clears_error", 64'(error), 64'd0);
    push_exp(32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    do_abort();
    do_start(4'd0);
    check_eq("cnt0_error",   64'(error),   64'd1);
    check_eq("cnt0_running", 64'(running), 64'd0);
    check_eq("cnt0_accel",   64'(accel),   64'd0);
    push_exp(32'd1000, 32'd0, 3'd0, 1'b0, 1'b0);
    do_start(4'd1);
    push_exp(32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    do_abort();
    do_start(4'd9);
    check_eq("cnt9_error",   64'(error),   64'd1);
    check_eq("cnt9_running", 64'(running), 64'd0);

    // RST mid-run together with tick and start.
    push_exp(32'd1000, 32'd0, 3'd0, 1'b0, 1'b0);
    do_start(4'd1);
    repeat (10) tick_once(1);
    check_eq("pre_rst_elapsed", 64'(elapsed), 64'd10);
    push_exp(32'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    RST = 1'b1; tick = 1'b1; start = 1'b1; seg_count = 4'd1;
    @(negedge CLK_50MHZ);
    RST = 1'b0; tick = 1'b0; start = 1'b0;
    check_eq("mid_rst_accel",   64'(accel),   64'd0);
    check_eq("mid_rst_running", 64'(running), 64'd0);
    check_eq("mid_rst_seg_idx", 64'(seg_idx), 64'd0);
    check_eq("mid_rst_elapsed", 64'(elapsed), 64'd0);
    check_eq("mid_rst_done",    64'(done),    64'd0);
    check_eq("mid_rst_error",   64'(error),   64'd0);
    cyc(3);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
